// File: rtl/exmem_bram_arbiter.sv
// Shares one single-port byte-writable BRAM between the Wishbone slave (stretched by DELAYS
// wait cycles to mimic slow external memory) and the FIR engine's req/gnt port.
module exmem_bram_arbiter #(
  parameter int unsigned N      = 14,
  parameter int unsigned DELAYS = 10,
  parameter logic [7:0]  BASE   = 8'h38
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          eng_req_i,
  input  logic          eng_we_i,
  input  logic [N-1:0]  eng_adr_i,
  input  logic [31:0]   eng_dat_i,
  output logic          eng_gnt_o,
  output logic          eng_rvalid_o,
  output logic [31:0]   eng_rdata_o,
  output logic          bram_en_o,
  output logic [3:0]    bram_we_o,
  output logic [31:0]   bram_di_o,
  output logic [N-1:0]  bram_a_o,
  input  logic [31:0]   bram_do_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWbDly = 2'd1;
  localparam logic [1:0] StWbAcc = 2'd2;
  localparam logic [1:0] StWbAck = 2'd3;

  localparam int unsigned    CntW    = (DELAYS > 1) ? $clog2(DELAYS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((DELAYS > 0) ? DELAYS - 1 : 0);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rr_eng_q, rr_eng_d;
  logic            lat_we_q, lat_we_d;
  logic [3:0]      lat_sel_q, lat_sel_d;
  logic [N-1:0]    lat_adr_q, lat_adr_d;
  logic [31:0]     lat_dat_q, lat_dat_d;
  logic            rvalid_q, rvalid_d;

  logic wb_hit, in_idle, wb_win, eng_gnt;

  // Address bits above the BRAM window alias; the byte offset is carried by sel.
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[23:N+2], wbs_adr_i[1:0]};

  assign wb_hit  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE);
  assign in_idle = (state_q == StIdle);
  assign wb_win  = in_idle & wb_hit & (~eng_req_i | ~rr_eng_q);
  assign eng_gnt = eng_req_i & ((in_idle & ~wb_win) | (state_q == StWbDly) |
                                (state_q == StWbAck));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_eng_d  = rr_eng_q;
    lat_we_d  = lat_we_q;
    lat_sel_d = lat_sel_q;
    lat_adr_d = lat_adr_q;
    lat_dat_d = lat_dat_q;
    case (state_q)
      StIdle: begin
        if (wb_win) begin
          lat_we_d  = wbs_we_i;
          lat_sel_d = wbs_sel_i;
          lat_adr_d = wbs_adr_i[N+1:2];
          lat_dat_d = wbs_dat_i;
          rr_eng_d  = 1'b1;
          cnt_d     = '0;
          state_d   = (DELAYS > 0) ? StWbDly : StWbAcc;
        end else if (eng_gnt && wb_hit) begin
          // Engine took this slot from a waiting Wishbone hit; Wishbone goes next.
          rr_eng_d = 1'b0;
        end
      end
      StWbDly: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StWbAcc;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWbAcc: state_d = StWbAck;
      StWbAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rvalid_d = eng_gnt & ~eng_we_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rr_eng_q  <= 1'b0;
      lat_we_q  <= 1'b0;
      lat_sel_q <= '0;
      lat_adr_q <= '0;
      lat_dat_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_eng_q  <= rr_eng_d;
      lat_we_q  <= lat_we_d;
      lat_sel_q <= lat_sel_d;
      lat_adr_q <= lat_adr_d;
      lat_dat_q <= lat_dat_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    bram_en_o = 1'b0;
    bram_we_o = '0;
    bram_di_o = '0;
    bram_a_o  = '0;
    if (state_q == StWbAcc) begin
      bram_en_o = 1'b1;
      bram_a_o  = lat_adr_q;
      bram_we_o = lat_we_q ? lat_sel_q : 4'h0;
      bram_di_o = lat_dat_q;
    end else if (eng_gnt) begin
      bram_en_o = 1'b1;
      bram_a_o  = eng_adr_i;
      bram_we_o = eng_we_i ? 4'hF : 4'h0;
      bram_di_o = eng_dat_i;
    end
  end

  assign wbs_ack_o    = (state_q == StWbAck);
  assign wbs_dat_o    = (wbs_ack_o && !lat_we_q) ? bram_do_i : 32'h0;
  assign eng_gnt_o    = eng_gnt;
  assign eng_rvalid_o = rvalid_q;
  assign eng_rdata_o  = rvalid_q ? bram_do_i : 32'h0;

endmodule
